duck_hit_detector: RTL and testbench

Shot evaluation block for the Duck Hunt game logic.
- Sits between the mouse interface and `duck_ctl`.
- Watches left-button presses and the duck's bounding box, and manages ammunition per duck.
- Drives `target_killed` for the hold time the duck controller needs to enter and stay in its falling state.
- Maintains a saturating hit score and a per-duck miss pulse for the HUD and round logic.

---
 rtl/duck_hit_detector_if.sv | 24 ++
 rtl/duck_hit_detector.sv | 147 ++++++++++++++
 tb/tb_duck_hit_detector.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/duck_hit_detector_if.sv
// Signal bundle between the mouse/duck_ctl side and duck_hit_detector.
// The master side drives the inputs; the detector uses the slave modport.
interface duck_hit_detector_if;
  logic        game_enable;
  logic        mouse_left;
  logic [11:0] mouse_xpos;
  logic [11:0] mouse_ypos;
  logic [11:0] duck_xpos;
  logic [11:0] duck_ypos;
  logic        target_killed;
  logic [1:0]  shots_left;
  logic [7:0]  score;
  logic        miss;

  modport master (
    output game_enable, mouse_left, mouse_xpos, mouse_ypos, duck_xpos, duck_ypos,
    input  target_killed, shots_left, score, miss
  );

  modport slave (
    input  game_enable, mouse_left, mouse_xpos, mouse_ypos, duck_xpos, duck_ypos,
    output target_killed, shots_left, score, miss
  );
endinterface

// File: rtl/duck_hit_detector.sv
// Duck Hunt shot evaluation: click edge detect, hitbox test, per-duck ammo, hit hold, score.
// Optional macro DUCK_HIT_MARGIN_EN widens the hitbox by 8 px on every side.
module duck_hit_detector #(
  parameter int GROUND      = 620,
  parameter int DUCK_WIDTH  = 96,
  parameter int DUCK_HEIGHT = 32,
  parameter int AMMO        = 3,
  parameter int HIT_HOLD    = 32_500_000
) (
  input  logic                clk,
  input  logic                rst,
  duck_hit_detector_if.slave  bus
);

  localparam int CW = $clog2(HIT_HOLD + 1);
  localparam logic [11:0]   GROUND_Y  = 12'(GROUND);
  localparam logic [12:0]   WIDTH_X   = 13'(DUCK_WIDTH);
  localparam logic [12:0]   HEIGHT_Y  = 13'(DUCK_HEIGHT);
  localparam logic [1:0]    AMMO_V    = 2'(AMMO);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HIT_HOLD - 1);

  typedef enum logic [1:0] {
    ST_WAIT_GROUND = 2'd0,
    ST_WAIT_FLY    = 2'd1,
    ST_ARMED       = 2'd2,
    ST_HOLD        = 2'd3
  } state_t;

  state_t        state_r, state_n;
  logic          btn_q_r;
  logic [CW-1:0] hold_cnt_r, hold_cnt_n;
  logic          target_killed_r, target_killed_n;
  logic [1:0]    shots_r, shots_n;
  logic [7:0]    score_r, score_n;
  logic          miss_r, miss_n;

  logic          click_s, inside_s;
  logic [12:0]   mx_s, my_s, x_lo_s, x_hi_s, y_lo_s, y_hi_s;
  logic [1:0]    shots_dec_s;
  logic [7:0]    score_inc_s;

  assign click_s = bus.mouse_left & ~btn_q_r;
  assign mx_s    = {1'b0, bus.mouse_xpos};
  assign my_s    = {1'b0, bus.mouse_ypos};

`ifdef DUCK_HIT_MARGIN_EN
  // Lower bounds clamp at zero so a duck near the screen edge cannot wrap.
  assign x_lo_s = (bus.duck_xpos >= 12'd8) ? ({1'b0, bus.duck_xpos} - 13'd8) : 13'd0;
  assign y_lo_s = (bus.duck_ypos >= 12'd8) ? ({1'b0, bus.duck_ypos} - 13'd8) : 13'd0;
  assign x_hi_s = {1'b0, bus.duck_xpos} + WIDTH_X + 13'd8;
  assign y_hi_s = {1'b0, bus.duck_ypos} + HEIGHT_Y + 13'd8;
`else
  assign x_lo_s = {1'b0, bus.duck_xpos};
  assign y_lo_s = {1'b0, bus.duck_ypos};
  assign x_hi_s = {1'b0, bus.duck_xpos} + WIDTH_X;
  assign y_hi_s = {1'b0, bus.duck_ypos} + HEIGHT_Y;
`endif

  assign inside_s    = (mx_s >= x_lo_s) & (mx_s < x_hi_s) & (my_s >= y_lo_s) & (my_s < y_hi_s);
  assign shots_dec_s = (shots_r != 2'd0) ? (shots_r - 2'd1) : 2'd0;
  assign score_inc_s = (score_r != 8'd255) ? (score_r + 8'd1) : score_r;

  // Next-state and next-output decode.
  always_comb begin
    state_n         = state_r;
    hold_cnt_n      = hold_cnt_r;
    shots_n         = shots_r;
    score_n         = score_r;
    target_killed_n = 1'b0;
    miss_n          = 1'b0;
    case (state_r)
      ST_WAIT_GROUND: begin
        if (bus.duck_ypos >= GROUND_Y) begin
          state_n = ST_WAIT_FLY;
        end else begin
          state_n = ST_WAIT_GROUND;
        end
      end
      ST_WAIT_FLY: begin
        if (bus.game_enable && (bus.duck_ypos < GROUND_Y)) begin
          state_n = ST_ARMED;
          shots_n = AMMO_V;
        end else begin
          state_n = ST_WAIT_FLY;
        end
      end
      ST_ARMED: begin
        if (!bus.game_enable) begin
          state_n = ST_WAIT_GROUND;
        end else if (click_s && inside_s) begin
          state_n         = ST_HOLD;
          shots_n         = shots_dec_s;
          score_n         = score_inc_s;
          hold_cnt_n      = '0;
          target_killed_n = 1'b1;
        end else if (click_s && (shots_r == 2'd1)) begin
          state_n = ST_WAIT_GROUND;
          shots_n = 2'd0;
          miss_n  = 1'b1;
        end else if (click_s) begin
          shots_n = shots_dec_s;
        end else begin
          state_n = ST_ARMED;
        end
      end
      ST_HOLD: begin
        // Game disable deliberately does not cut the hold short.
        if (hold_cnt_r == HOLD_LAST) begin
          state_n = ST_WAIT_GROUND;
        end else begin
          hold_cnt_n      = hold_cnt_r + CW'(1);
          target_killed_n = 1'b1;
        end
      end
      default: begin
        state_n = ST_WAIT_GROUND;
      end
    endcase
  end

  // State, button history and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r         <= ST_WAIT_GROUND;
      btn_q_r         <= 1'b0;
      hold_cnt_r      <= '0;
      target_killed_r <= 1'b0;
      shots_r         <= 2'd0;
      score_r         <= 8'd0;
      miss_r          <= 1'b0;
    end else begin
      state_r         <= state_n;
      btn_q_r         <= bus.mouse_left;
      hold_cnt_r      <= hold_cnt_n;
      target_killed_r <= target_killed_n;
      shots_r         <= shots_n;
      score_r         <= score_n;
      miss_r          <= miss_n;
    end
  end

  assign bus.target_killed = target_killed_r;
  assign bus.shots_left    = shots_r;
  assign bus.score         = score_r;
  assign bus.miss          = miss_r;

endmodule

// File: tb/tb_duck_hit_detector.sv
// Directed self-checking bench for duck_hit_detector with HIT_HOLD=10, AMMO=3.
module tb_duck_hit_detector;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  duck_hit_detector_if bus ();

  duck_hit_detector #(
    .GROUND(620), .DUCK_WIDTH(96), .DUCK_HEIGHT(32), .AMMO(3), .HIT_HOLD(10)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic arm(input logic [11:0] fly_y);
    bus.game_enable = 1'b1;
    bus.duck_ypos   = 12'd620;
    tick(1);
    bus.duck_ypos   = fly_y;
    tick(1);
  endtask

  task automatic click(input logic [11:0] x, input logic [11:0] y);
    bus.mouse_xpos = x;
    bus.mouse_ypos = y;
    bus.mouse_left = 1'b1;
    tick(1);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick(2);
    n_checks++; if (bus.target_killed !== 1'b0) begin n_fail++; $display("FAIL reset_tk: got %b want 0", bus.target_killed); end
    n_checks++; if (bus.shots_left !== 2'd0) begin n_fail++; $display("FAIL reset_shots: got %0d want 0", bus.shots_left); end
    n_checks++; if (bus.score !== 8'd0) begin n_fail++; $display("FAIL reset_score: got %0d want 0", bus.score); end
    n_checks++; if (bus.miss !== 1'b0) begin n_fail++; $display("FAIL reset_miss: got %b want 0", bus.miss); end
    rst = 1'b0;
    tick(1);
  endtask

  task automatic test_arm;
    arm(12'd588);
    n_checks++; if (bus.shots_left !== 2'd3) begin n_fail++; $display("FAIL arm_shots: got %0d want 3", bus.shots_left); end
    n_checks++; if (bus.target_killed !== 1'b0) begin n_fail++; $display("FAIL arm_tk: got %b want 0", bus.target_killed); end
    n_checks++; if (bus.score !== 8'd0) begin n_fail++; $display("FAIL arm_score: got %0d want 0", bus.score); end
  endtask

  task automatic test_hit;
    int high_cycles;
    bus.duck_xpos = 12'd200;
    bus.duck_ypos = 12'd300;
    tick(1);
    click(12'd250, 12'd310);
    n_checks++; if (bus.target_killed !== 1'b1) begin n_fail++; $display("FAIL hit_tk: got %b want 1", bus.target_killed); end
    n_checks++; if (bus.score !== 8'd1) begin n_fail++; $display("FAIL hit_score: got %0d want 1", bus.score); end
    n_checks++; if (bus.shots_left !== 2'd2) begin n_fail++; $display("FAIL hit_shots: got %0d want 2", bus.shots_left); end
    bus.mouse_left = 1'b0;
    high_cycles = 1;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (bus.target_killed === 1'b1) high_cycles++;
      else break;
    end
    n_checks++; if (high_cycles !== 10) begin n_fail++; $display("FAIL hit_hold_len: got %0d want 10", high_cycles); end
  endtask

  task automatic test_miss;
    arm(12'd300);
    click(12'd296, 12'd310);
    n_checks++; if (bus.shots_left !== 2'd2) begin n_fail++; $display("FAIL miss_shots1: got %0d want 2", bus.shots_left); end
    bus.mouse_left = 1'b0; tick(1);
    click(12'd296, 12'd310);
    n_checks++; if (bus.shots_left !== 2'd1) begin n_fail++; $display("FAIL miss_shots2: got %0d want 1", bus.shots_left); end
    n_checks++; if (bus.miss !== 1'b0) begin n_fail++; $display("FAIL miss_early: got %b want 0", bus.miss); end
    bus.mouse_left = 1'b0; tick(1);
    click(12'd296, 12'd310);
    n_checks++; if (bus.shots_left !== 2'd0) begin n_fail++; $display("FAIL miss_shots3: got %0d want 0", bus.shots_left); end
    n_checks++; if (bus.miss !== 1'b1) begin n_fail++; $display("FAIL miss_pulse: got %b want 1", bus.miss); end
    n_checks++; if (bus.target_killed !== 1'b0) begin n_fail++; $display("FAIL miss_tk: got %b want 0", bus.target_killed); end
    bus.mouse_left = 1'b0; tick(1);
    n_checks++; if (bus.miss !== 1'b0) begin n_fail++; $display("FAIL miss_one_cycle: got %b want 0", bus.miss); end
    n_checks++; if (bus.score !== 8'd1) begin n_fail++; $display("FAIL miss_score: got %0d want 1", bus.score); end
  endtask

  task automatic test_held_button;
    arm(12'd300);
    click(12'd250, 12'd310);
    n_checks++; if (bus.score !== 8'd2) begin n_fail++; $display("FAIL held_first: got %0d want 2", bus.score); end
    tick(14);
    bus.duck_ypos = 12'd620; tick(1);
    bus.duck_ypos = 12'd300; tick(1);
    n_checks++; if (bus.shots_left !== 2'd3) begin n_fail++; $display("FAIL held_rearm: got %0d want 3", bus.shots_left); end
    tick(33);
    n_checks++; if (bus.target_killed !== 1'b0) begin n_fail++; $display("FAIL held_no_tk: got %b want 0", bus.target_killed); end
    n_checks++; if (bus.score !== 8'd2) begin n_fail++; $display("FAIL held_no_score: got %0d want 2", bus.score); end
    bus.mouse_left = 1'b0; tick(1);
    click(12'd250, 12'd310);
    n_checks++; if (bus.target_killed !== 1'b1) begin n_fail++; $display("FAIL held_repress_tk: got %b want 1", bus.target_killed); end
    n_checks++; if (bus.score !== 8'd3) begin n_fail++; $display("FAIL held_repress_score: got %0d want 3", bus.score); end
    bus.mouse_left = 1'b0;
    tick(12);
  endtask

  task automatic test_enable_drop;
    arm(12'd300);
    bus.game_enable = 1'b0;
    click(12'd250, 12'd310);
    n_checks++; if (bus.target_killed !== 1'b0) begin n_fail++; $display("FAIL drop_tk: got %b want 0", bus.target_killed); end
    n_checks++; if (bus.score !== 8'd3) begin n_fail++; $display("FAIL drop_score: got %0d want 3", bus.score); end
    bus.mouse_left = 1'b0; tick(1);
    bus.game_enable = 1'b1;
    click(12'd250, 12'd310);
    n_checks++; if (bus.target_killed !== 1'b0) begin n_fail++; $display("FAIL drop_disarmed: got %b want 0", bus.target_killed); end
    bus.mouse_left = 1'b0; tick(1);
  endtask

  task automatic test_reset_in_hold;
    arm(12'd300);
    click(12'd250, 12'd310);
    bus.mouse_left = 1'b0;
    tick(5);
    n_checks++; if (bus.target_killed !== 1'b1) begin n_fail++; $display("FAIL rsthold_pre: got %b want 1", bus.target_killed); end
    rst = 1'b1; tick(1);
    n_checks++; if (bus.target_killed !== 1'b0) begin n_fail++; $display("FAIL rsthold_tk: got %b want 0", bus.target_killed); end
    n_checks++; if (bus.score !== 8'd0) begin n_fail++; $display("FAIL rsthold_score: got %0d want 0", bus.score); end
    rst = 1'b0; tick(1);
  endtask

  task automatic test_boundary;
`ifdef DUCK_HIT_MARGIN_EN
    bus.duck_xpos = 12'd4;
    arm(12'd300);
    click(12'd0, 12'd305);
    n_checks++; if (bus.target_killed !== 1'b1) begin n_fail++; $display("FAIL margin_clamp_hit: got %b want 1", bus.target_killed); end
    n_checks++; if (bus.score !== 8'd1) begin n_fail++; $display("FAIL margin_score: got %0d want 1", bus.score); end
`else
    bus.duck_xpos = 12'd200;
    arm(12'd300);
    click(12'd202, 12'd296);
    n_checks++; if (bus.target_killed !== 1'b0) begin n_fail++; $display("FAIL above_top_tk: got %b want 0", bus.target_killed); end
    n_checks++; if (bus.shots_left !== 2'd2) begin n_fail++; $display("FAIL above_top_shots: got %0d want 2", bus.shots_left); end
    bus.mouse_left = 1'b0; tick(1);
    click(12'd250, 12'd332);
    n_checks++; if (bus.target_killed !== 1'b0) begin n_fail++; $display("FAIL bottom_excl_tk: got %b want 0", bus.target_killed); end
    n_checks++; if (bus.shots_left !== 2'd1) begin n_fail++; $display("FAIL bottom_excl_shots: got %0d want 1", bus.shots_left); end
    bus.mouse_left = 1'b0; tick(1);
    click(12'd200, 12'd300);
    n_checks++; if (bus.target_killed !== 1'b1) begin n_fail++; $display("FAIL corner_incl_tk: got %b want 1", bus.target_killed); end
    n_checks++; if (bus.shots_left !== 2'd0) begin n_fail++; $display("FAIL corner_incl_shots: got %0d want 0", bus.shots_left); end
    n_checks++; if (bus.miss !== 1'b0) begin n_fail++; $display("FAIL corner_incl_miss: got %b want 0", bus.miss); end
`endif
    bus.mouse_left = 1'b0;
    tick(12);
  endtask

  initial begin
    n_checks        = 0;
    n_fail          = 0;
    rst             = 1'b1;
    bus.game_enable = 1'b0;
    bus.mouse_left  = 1'b0;
    bus.mouse_xpos  = 12'd0;
    bus.mouse_ypos  = 12'd0;
    bus.duck_xpos   = 12'd200;
    bus.duck_ypos   = 12'd620;
    @(negedge clk);
    test_reset();
    test_arm();
    test_hit();
    test_miss();
    test_held_button();
    test_enable_drop();
    test_reset_in_hold();
    test_boundary();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
